// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: segment code table and
// the all-segments-off pattern. Codes are active-high, ordered {g,f,e,d,c,b,a}.
package seg7_scan_driver_pkg;

   localparam logic [6:0] SEG_OFF = 7'b0000000;

   localparam logic [6:0] SEG_CODE [16] = '{
      7'b0111111,  // 0
      7'b0000110,  // 1
      7'b1011011,  // 2
      7'b1001111,  // 3
      7'b1100110,  // 4
      7'b1101101,  // 5
      7'b1111101,  // 6
      7'b0000111,  // 7
      7'b1111111,  // 8
      7'b1101111,  // 9
      7'b1110111,  // A
      7'b1111100,  // b
      7'b0111001,  // C
      7'b1011110,  // d
      7'b1111001,  // E
      7'b1110001   // F
   };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment code.
// Pin polarity is handled by the top so this stays a pure table lookup.
module seg7_hex_decode
   import seg7_scan_driver_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] code
);

   assign code = SEG_CODE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver. A prescaler walks a digit index
// across the display; inputs land in a shadow register and are committed to
// the display register only at frame boundaries so a frame never mixes old
// and new values. Blink, blanking and leading-zero suppression darken digits;
// a short dead time at the start of each slot turns all anodes off.
module seg7_scan_driver
   import seg7_scan_driver_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int DEAD_CYC       = 2,
   parameter int BLINK_DIV      = 32,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic [NUM_DIGITS-1:0]   blink_en,
   input  logic                    lz_suppress,
   input  logic                    load,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);

   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [FW-1:0] frm;
   logic          phase;
   logic          slot_end, boundary;

   // shadow (captured on load) and display (committed at frame boundary)
   logic [4*NUM_DIGITS-1:0] sh_value, d_value;
   logic [NUM_DIGITS-1:0]   sh_dp, sh_blank, sh_blink;
   logic [NUM_DIGITS-1:0]   d_dp, d_blank, d_blink;
   logic                    sh_lz, d_lz, pending;

   logic [NUM_DIGITS-1:0] lz_mask, onehot;
   logic                  zrun;
   logic [3:0]            nib;
   logic [6:0]            code;
   logic                  cur_dp, cur_blank, cur_supp;
   logic                  dark, dp_on, dead, an_on;

   assign slot_end = (cnt == CNT_LAST);
   assign boundary = slot_end && (idx == IDX_LAST);

   // prescaler counts out each slot, then advances the digit index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // frame counter; blink phase flips each time it wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frm   <= '0;
         phase <= 1'b0;
      end else if (boundary) begin
         if (frm == FRM_LAST) begin
            frm   <= '0;
            phase <= ~phase;
         end else begin
            frm <= frm + 1'b1;
         end
      end
   end

   // shadow capture and tear-free commit; a load on the boundary goes straight through
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_value <= '0; sh_dp <= '0; sh_blank <= '0; sh_blink <= '0; sh_lz <= 1'b0;
         d_value  <= '0; d_dp  <= '0; d_blank  <= '0; d_blink  <= '0; d_lz  <= 1'b0;
         pending  <= 1'b0;
      end else if (boundary && load) begin
         sh_value <= value; sh_dp <= dp_in; sh_blank <= blank_mask; sh_blink <= blink_en; sh_lz <= lz_suppress;
         d_value  <= value; d_dp  <= dp_in; d_blank  <= blank_mask; d_blink  <= blink_en; d_lz  <= lz_suppress;
         pending  <= 1'b0;
      end else begin
         if (load) begin
            sh_value <= value; sh_dp <= dp_in; sh_blank <= blank_mask; sh_blink <= blink_en; sh_lz <= lz_suppress;
            pending  <= 1'b1;
         end
         if (boundary && pending) begin
            d_value <= sh_value; d_dp <= sh_dp; d_blank <= sh_blank; d_blink <= sh_blink; d_lz <= sh_lz;
            pending <= 1'b0;
         end
      end
   end

   // leading zeros: a digit is suppressed while every digit above it (and itself) is zero
   always_comb begin
      lz_mask = '0;
      zrun    = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zrun       = zrun & (d_value[4*i +: 4] == 4'h0);
         lz_mask[i] = d_lz & zrun;
      end
   end

   // pick out the attributes of the digit currently being scanned
   always_comb begin
      nib       = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      cur_supp  = 1'b0;
      onehot    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            nib       = d_value[4*i +: 4];
            cur_dp    = d_dp[i];
            cur_blank = d_blank[i] | (d_blink[i] & phase);
            cur_supp  = lz_mask[i];
            onehot[i] = 1'b1;
         end
      end
   end

   seg7_hex_decode u_dec (
      .nibble (nib),
      .code   (code)
   );

   // blanking/blink kill the dp too; a suppressed zero keeps its dp and anode
   assign dark  = cur_blank | cur_supp;
   assign dp_on = cur_dp & ~cur_blank;
   assign dead  = (int'(cnt) < DEAD_CYC);
   assign an_on = ~dead & (~dark | dp_on);

   // registered pin drivers with polarity applied
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg        <= {7{SEG_ACTIVE_LOW}};
         dp         <= SEG_ACTIVE_LOW;
         an         <= {NUM_DIGITS{AN_ACTIVE_LOW}};
         frame_tick <= 1'b0;
      end else begin
         seg        <= (dark ? SEG_OFF : code) ^ {7{SEG_ACTIVE_LOW}};
         dp         <= dp_on ^ SEG_ACTIVE_LOW;
         an         <= (an_on ? onehot : '0) ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
         frame_tick <= boundary;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: random loads checked every cycle against a
// frame-level reference model built from the load history.
module tb_seg7_scan_driver;

   localparam int N  = 4;
   localparam int SD = 4;
   localparam int DC = 1;
   localparam int BD = 2;
   localparam int FR = N * SD;
   localparam logic [12:0] RST_OUT = {4'b1111, 7'b0000000, 1'b0, 1'b0};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [15:0]   value = '0;
   logic [3:0]    dp_in = '0, blank_mask = '0, blink_en = '0;
   logic          lz_suppress = 1'b0, load = 1'b0;
   logic [6:0]    seg;
   logic          dp;
   logic [3:0]    an;
   logic          frame_tick;

   seg7_scan_driver #(
      .NUM_DIGITS(N), .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_DIV(BD),
      .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
      .blank_mask(blank_mask), .blink_en(blink_en), .lz_suppress(lz_suppress),
      .load(load), .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   // cycles elapsed since reset release = DUT scan time
   int cyc;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   typedef struct {
      int          s;
      logic [15:0] v;
      logic [3:0]  dpv, bm, be;
      logic        lz;
   } ld_t;

   ld_t hist[$];
   logic [6:0] CODE [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int n_cmp = 0;
   int n_bad = 0;
   logic [12:0] obs, exp_v;
   assign obs = {an, seg, dp, frame_tick};

   // expected {an,seg,dp,tick} produced by scan time s: the frame shows the last load
   // made in any earlier frame; blink phase is set by which pair of frames we are in
   function automatic logic [12:0] model(int s);
      int f, sl, c;
      ld_t cur;
      logic [3:0] nib, anv;
      logic supp, bl, dpv;
      logic [6:0] segv;
      f = s / FR; sl = (s / SD) % N; c = s % SD;
      cur.s = 0; cur.v = '0; cur.dpv = '0; cur.bm = '0; cur.be = '0; cur.lz = 1'b0;
      foreach (hist[k]) if (hist[k].s / FR < f) cur = hist[k];
      nib  = cur.v[sl*4 +: 4];
      supp = cur.lz && (sl != 0) && ((cur.v >> (4*sl)) == 16'h0);
      bl   = cur.bm[sl] || (cur.be[sl] && ((f / BD) % 2 == 1));
      segv = (bl || supp) ? 7'h00 : CODE[nib];
      dpv  = bl ? 1'b0 : cur.dpv[sl];
      anv  = (c >= DC && (!(bl || supp) || dpv)) ? 4'(1 << sl) : 4'b0000;
      return {~anv, segv, dpv, (s % FR == FR - 1)};
   endfunction

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                          input logic [3:0] e, input logic z);
      ld_t r;
      value = v; dp_in = d; blank_mask = b; blink_en = e; lz_suppress = z; load = 1'b1;
      r.s = cyc; r.v = v; r.dpv = d; r.bm = b; r.be = e; r.lz = z;
      hist.push_back(r);
   endtask

   task automatic test_reset();
      int waited;
      rst_n = 1'b0; hist.delete();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (obs !== RST_OUT) begin
         n_bad++; $display("FAIL reset_state got=%b exp=%b", obs, RST_OUT);
      end
      rst_n = 1'b1;
      waited = 0;
      while (!frame_tick && waited < 40) begin
         @(negedge clk); waited++;
         exp_v = (cyc == 0) ? RST_OUT : model(cyc - 1);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++; $display("FAIL reset_scan cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
      end
      n_cmp++;
      if (cyc !== 16) begin
         n_bad++; $display("FAIL first_tick got_cycles=%0d exp_cycles=16", cyc);
      end
   endtask

   task automatic test_scan();
      for (int k = 0; k < 3*FR; k++) begin
         @(negedge clk);
         n_cmp++; exp_v = model(cyc - 1);
         if (obs !== exp_v) begin
            n_bad++; $display("FAIL scan_12af cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
         load = 1'b0;
         if (k == 0) do_load(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0);
      end
   endtask

   task automatic test_lz();
      for (int k = 0; k < 6*FR; k++) begin
         @(negedge clk);
         n_cmp++; exp_v = model(cyc - 1);
         if (obs !== exp_v) begin
            n_bad++; $display("FAIL lz cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
         load = 1'b0;
         if (k == 0)      do_load(16'h0005, 4'h0, 4'h0, 4'h0, 1'b1);
         if (k == 2*FR)   do_load(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1);
         if (k == 4*FR)   do_load(16'h0030, 4'b0100, 4'h0, 4'h0, 1'b1);
      end
   endtask

   task automatic test_shadow();
      int b;
      for (int k = 0; k < 8*FR; k++) begin
         @(negedge clk);
         n_cmp++; exp_v = model(cyc - 1);
         if (obs !== exp_v) begin
            n_bad++; $display("FAIL shadow cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
         load = 1'b0;
         if (k == 0) do_load(16'h2222, 4'h0, 4'h0, 4'h0, 1'b0);
         if (k == 2*FR + 5) do_load(16'h1111, 4'h0, 4'h0, 4'h0, 1'b0);
         // boundary-cycle load goes live on the very next frame
         if (k > 4*FR && k < 5*FR && cyc % FR == FR - 1) do_load(16'h3C4D, 4'b1010, 4'h0, 4'h0, 1'b0);
         // back-to-back loads: the second must win
         if (k == 6*FR + 3) do_load(16'hAAAA, 4'hF, 4'h0, 4'h0, 1'b0);
         if (k == 6*FR + 4) do_load(16'h9876, 4'h1, 4'h0, 4'h0, 1'b0);
      end
      b = 0;
   endtask

   task automatic test_blink();
      for (int k = 0; k < 9*FR; k++) begin
         @(negedge clk);
         n_cmp++; exp_v = model(cyc - 1);
         if (obs !== exp_v) begin
            n_bad++; $display("FAIL blink cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
         load = 1'b0;
         if (k == 0) do_load(16'h8421, 4'b0011, 4'h0, 4'b0001, 1'b0);
      end
   endtask

   task automatic test_random();
      int at;
      for (int r = 0; r < 12; r++) begin
         at = $urandom_range(0, FR - 1);
         for (int k = 0; k < 3*FR; k++) begin
            @(negedge clk);
            n_cmp++; exp_v = model(cyc - 1);
            if (obs !== exp_v) begin
               n_bad++; $display("FAIL random r=%0d cyc=%0d got=%b exp=%b", r, cyc, obs, exp_v);
            end
            load = 1'b0;
            if (k == at)
               do_load(16'($urandom), 4'($urandom), 4'($urandom_range(0, 1) ? $urandom : 0),
                       4'($urandom), 1'($urandom));
         end
      end
   endtask

   task automatic test_reset_mid();
      int waited;
      waited = 0;
      while (!(cyc % FR == SD) && waited < 40) begin @(negedge clk); waited++; end
      load = 1'b0;
      do_load(16'h3333, 4'h0, 4'h0, 4'h0, 1'b0);
      @(negedge clk);
      load = 1'b0;
      while (!((cyc / SD) % N == 2) && waited < 80) begin @(negedge clk); waited++; end
      n_cmp++;
      if (waited >= 80) begin
         n_bad++; $display("FAIL reset_mid_align got=%0d exp<80", waited);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (obs !== RST_OUT) begin
         n_bad++; $display("FAIL reset_mid_async got=%b exp=%b", obs, RST_OUT);
      end
      hist.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3*FR; k++) begin
         @(negedge clk);
         n_cmp++; exp_v = (cyc == 0) ? RST_OUT : model(cyc - 1);
         if (obs !== exp_v) begin
            n_bad++; $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_lz();
      test_shadow();
      test_blink();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
